// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter.
// Holds FU request / CDB packet bundles and sizing constants.
package cdb_arbiter_pkg;

   localparam int CDB_N        = 2;
   localparam int NUM_REQ      = 8;
   localparam int STARVE_LIMIT = 4;
   localparam int CDB_PRN_W    = 6;
   localparam int CDB_ROBN_W   = 5;
   localparam int CDB_XLEN     = 32;
   localparam int REQ_IDX_W    = $clog2(NUM_REQ);

   typedef struct packed {
      logic [CDB_PRN_W-1:0]  prn;
      logic [CDB_XLEN-1:0]   value;
      logic [CDB_ROBN_W-1:0] robn;
   } fu_cdb_req_t;

   typedef struct packed {
      logic                  valid;
      logic [CDB_PRN_W-1:0]  dest_prn;
      logic [CDB_XLEN-1:0]   value;
      logic [CDB_ROBN_W-1:0] robn;
   } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Circular priority picker: up to i_limit (<= N) bits of i_mask,
// scanning from i_start. Ports: i_mask, i_start, i_limit in;
// o_grant (one-hot set), o_vld/o_idx (picks in scan order),
// o_any, o_last (index of final pick) out.
module cdb_arbiter_rr_select
   import cdb_arbiter_pkg::*;
#(
   parameter int N = CDB_N
) (
   input  logic [NUM_REQ-1:0]     i_mask,
   input  logic [REQ_IDX_W-1:0]   i_start,
   input  logic [$clog2(N+1)-1:0] i_limit,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic [N-1:0]           o_vld,
   output logic [REQ_IDX_W-1:0]   o_idx [N],
   output logic                   o_any,
   output logic [REQ_IDX_W-1:0]   o_last
);

   always_comb begin : pick
      int n;
      int p;
      logic [REQ_IDX_W-1:0] v_p;
      n       = 0;
      p       = 0;
      v_p     = '0;
      o_grant = '0;
      o_vld   = '0;
      o_any   = 1'b0;
      o_last  = '0;
      for (int k = 0; k < N; k++) begin
         o_idx[k] = '0;
      end
      for (int s = 0; s < NUM_REQ; s++) begin
         p = int'(i_start) + s;
         if (p >= NUM_REQ) begin
            p = p - NUM_REQ;
         end
         v_p = REQ_IDX_W'(p);
         if (i_mask[v_p] && (n < int'(i_limit))) begin
            for (int k = 0; k < N; k++) begin
               if (n == k) begin
                  o_idx[k] = v_p;
                  o_vld[k] = 1'b1;
               end
            end
            o_grant[v_p] = 1'b1;
            o_any        = 1'b1;
            o_last       = v_p;
            n            = n + 1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to N FU completions per cycle (starved
// first, then round-robin) and registers winners onto the CDB.
// In: clock, reset (async low), squash, req + per-req prn/value/robn.
// Out: grant (comb), cdb_valid/prn/value/robn (reg), rr_ptr_dbg.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N = CDB_N
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          squash,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*CDB_PRN_W-1:0]  req_prn,
   input  logic [NUM_REQ*CDB_XLEN-1:0]   req_value,
   input  logic [NUM_REQ*CDB_ROBN_W-1:0] req_robn,
   output logic [NUM_REQ-1:0]            grant,
   output logic [N-1:0]                  cdb_valid,
   output logic [N*CDB_PRN_W-1:0]        cdb_prn,
   output logic [N*CDB_XLEN-1:0]         cdb_value,
   output logic [N*CDB_ROBN_W-1:0]       cdb_robn,
   output logic [REQ_IDX_W-1:0]          rr_ptr_dbg
);

   localparam int CNT_W  = $clog2(N + 1);
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

   fu_cdb_req_t          w_fu [NUM_REQ];
   logic [NUM_REQ-1:0]   w_req;
   logic [NUM_REQ-1:0]   w_starved;
   logic [NUM_REQ-1:0]   w_st_grant;
   logic [N-1:0]         w_st_vld;
   logic [REQ_IDX_W-1:0] w_st_idx [N];
   logic [CNT_W-1:0]     w_st_cnt;
   logic [NUM_REQ-1:0]   w_rr_mask;
   logic [CNT_W-1:0]     w_rr_limit;
   logic [NUM_REQ-1:0]   w_rr_grant;
   logic [N-1:0]         w_rr_vld;
   logic [REQ_IDX_W-1:0] w_rr_idx [N];
   logic                 w_rr_any;
   logic [REQ_IDX_W-1:0] w_rr_last;
   logic [N-1:0]         w_slot_vld;
   logic [REQ_IDX_W-1:0] w_slot_idx [N];

   logic [REQ_IDX_W-1:0] r_rr_ptr;
   logic [WAIT_W-1:0]    r_wait [NUM_REQ];
   cdb_packet_t          r_cdb [N];

   // Requests are masked out during reset and squash so that
   // every downstream grant path sees nothing.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_fu[i].prn   = req_prn[i*CDB_PRN_W +: CDB_PRN_W];
         w_fu[i].value = req_value[i*CDB_XLEN +: CDB_XLEN];
         w_fu[i].robn  = req_robn[i*CDB_ROBN_W +: CDB_ROBN_W];
      end
      w_req = req & {NUM_REQ{reset & ~squash}};
      for (int i = 0; i < NUM_REQ; i++) begin
         w_starved[i] = w_req[i]
                     && (r_wait[i] >= WAIT_W'(STARVE_LIMIT));
      end
   end

   // Fixed-priority pass over the starved set, lowest index first.
   always_comb begin : st_pick
      int n;
      n          = 0;
      w_st_grant = '0;
      w_st_vld   = '0;
      for (int k = 0; k < N; k++) begin
         w_st_idx[k] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_starved[i] && (n < N)) begin
            for (int k = 0; k < N; k++) begin
               if (n == k) begin
                  w_st_idx[k] = REQ_IDX_W'(i);
                  w_st_vld[k] = 1'b1;
               end
            end
            w_st_grant[i] = 1'b1;
            n             = n + 1;
         end
      end
      w_st_cnt = CNT_W'(n);
   end

   assign w_rr_mask  = w_req & ~w_starved;
   assign w_rr_limit = CNT_W'(N) - w_st_cnt;

   cdb_arbiter_rr_select #(
      .N (N)
   ) u_rr_select (
      .i_mask  (w_rr_mask),
      .i_start (r_rr_ptr),
      .i_limit (w_rr_limit),
      .o_grant (w_rr_grant),
      .o_vld   (w_rr_vld),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any),
      .o_last  (w_rr_last)
   );

   assign grant = w_st_grant | w_rr_grant;

   // Starved winners take the low slots; round-robin winners
   // follow directly behind them in scan order.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         w_slot_vld[k] = 1'b0;
         w_slot_idx[k] = '0;
         if (w_st_vld[k]) begin
            w_slot_vld[k] = 1'b1;
            w_slot_idx[k] = w_st_idx[k];
         end else begin
            for (int j = 0; j < N; j++) begin
               if ((j + int'(w_st_cnt) == k) && w_rr_vld[j]) begin
                  w_slot_vld[k] = 1'b1;
                  w_slot_idx[k] = w_rr_idx[j];
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rr_ptr <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_wait[i] <= '0;
         end
         for (int k = 0; k < N; k++) begin
            r_cdb[k] <= '0;
         end
      end else if (squash) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_wait[i] <= '0;
         end
         for (int k = 0; k < N; k++) begin
            r_cdb[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (w_slot_vld[k]) begin
               r_cdb[k] <= '{
                  valid    : 1'b1,
                  dest_prn : w_fu[w_slot_idx[k]].prn,
                  value    : w_fu[w_slot_idx[k]].value,
                  robn     : w_fu[w_slot_idx[k]].robn
               };
            end else begin
               r_cdb[k] <= '0;
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_req[i] && !grant[i]) begin
               if (r_wait[i] != WAIT_W'(STARVE_LIMIT)) begin
                  r_wait[i] <= r_wait[i] + 1'b1;
               end
            end else begin
               r_wait[i] <= '0;
            end
         end
         // Starved-only cycles leave the pointer alone.
         if (w_rr_any) begin
            if (w_rr_last == REQ_IDX_W'(NUM_REQ - 1)) begin
               r_rr_ptr <= '0;
            end else begin
               r_rr_ptr <= w_rr_last + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         cdb_valid[k] = r_cdb[k].valid;
         cdb_prn[k*CDB_PRN_W +: CDB_PRN_W] = r_cdb[k].dest_prn;
         cdb_value[k*CDB_XLEN +: CDB_XLEN] = r_cdb[k].value;
         cdb_robn[k*CDB_ROBN_W +: CDB_ROBN_W] = r_cdb[k].robn;
      end
   end

   assign rr_ptr_dbg = r_rr_ptr;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the N-wide common data bus among all FU completion requesters (ALU, MULT, LOAD), up to N grants per cycle.
- Sits between the FU bank and the CDB consumers (RS wakeup, PRF write, ROB complete).
- Uses rotating priority with a starvation override, and registers the winning payloads onto the CDB.

Parameters:
- N, 2, CDB width (grants per cycle).
- NUM_REQ, 8, number of completion requesters (NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD).
- PRN_W, 6, physical register index width.
- ROBN_W, 5, ROB index width.
- XLEN, 32, result value width.
- STARVE_LIMIT, 4, wait cycles after which a requester is forced to top priority.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  pipeline flush from ROB.
- req  in  NUM_REQ  completion request per FU.
- req_prn  in  NUM_REQ*PRN_W  destination PRN per requester.
- req_value  in  NUM_REQ*XLEN  result per requester.
- req_robn  in  NUM_REQ*ROBN_W  ROB index per requester.
- grant  out  NUM_REQ  combinational grant; at most N bits set.
- cdb_valid  out  N  registered CDB slot valid.
- cdb_prn  out  N*PRN_W  registered slot PRN.
- cdb_value  out  N*XLEN  registered slot value.
- cdb_robn  out  N*ROBN_W  registered slot ROB index.
- rr_ptr_dbg  out  clog2(NUM_REQ)  current rotating pointer (debug).

Behaviour:
- Reset (reset==0, async): cdb_valid=0, cdb_prn/value/robn=0, rr_ptr=0, all wait counters=0. grant is 0 while reset is asserted.
- Handshake:
  - A requester holds req=1 with stable payload until it sees grant=1 in the same cycle.
  - Transfer occurs on req&grant at the rising edge.
  - A requester may re-request the following cycle.
  - grant is never asserted without req.
- Selection, each cycle, combinational:
  1. Starved set = req & (wait_cnt >= STARVE_LIMIT). Grant the starved set in ascending index order first.
  2. Fill the remaining slots from non-starved requesters, scanning circularly from rr_ptr.
  3. Total grants = min(N, popcount(req)).
- Slot ordering: winners occupy CDB slots 0..k-1 in selection order. Unused slots have cdb_valid=0 and payload 0.
- Latency: payload granted in cycle t appears on cdb_* in cycle t+1, valid for exactly one cycle.
- rr_ptr update: if any non-starved grant was issued, rr_ptr <= (index of last non-starved winner + 1) mod NUM_REQ. Otherwise it is unchanged. Wrap-around from NUM_REQ-1 goes to 0.
- Wait counters:
  - If req&!grant, wait_cnt += 1, saturating at STARVE_LIMIT.
  - If grant or !req, wait_cnt <= 0.
- Squash (synchronous, priority over everything else):
  - grant=0 the same cycle.
  - Next edge: cdb_valid=0, all wait_cnt=0. rr_ptr is held.
  - A CDB entry already registered before the squash edge is dropped at that edge.
- Starvation overflow: if more than N requesters are starved, the lowest N indices win. The rest keep saturated counters and win on following cycles.
- No requests: grant=0, next cycle cdb_valid=0, rr_ptr held.
- Invariants: popcount(grant) <= N, and no duplicate PRN entries are granted by the arbiter itself.

Decomposition:
- Shared package holds:
  - CDB_PACKET (valid, dest_prn, value, robn).
  - FU_CDB_REQ (prn, value, robn).
  - Constants NUM_REQ and STARVE_LIMIT.
- One natural sub-module, rr_select: a combinational circular priority picker of up to N bits from a mask and a start pointer. It is instantiated for the non-starved pass; the starved pass uses a fixed-priority picker.

Test Plan:
- Reset mid-operation: req=8'hFF for 3 cycles, then reset=0 asynchronously between edges -> cdb_valid=0 immediately, rr_ptr=0, grant=0; after release, first grants are {0,1}.
- Round-robin: N=2, req=8'hFF held with re-requests every cycle -> grants {0,1},{2,3},{4,5},{6,7},{0,1}; rr_ptr sequence 2,4,6,0.
- One-cycle latency and slot order: req=8'b0010_0100 at cycle t -> grant=8'b0010_0100 at t; at t+1 cdb_valid=2'b11 with slot0=req2 payload, slot1=req5 payload.
- Starvation: requesters 0,1 request every cycle; req7 held continuously; rr_ptr forced so req7 loses 4 times -> cycle 5 grant includes bit 7 regardless of rr_ptr, and wait_cnt[7] returns to 0.
- Squash: req=8'h0F with squash=1 -> grant=0; next cycle cdb_valid=0 even though the prior cycle's grants were registered; counters are 0 and rr_ptr is unchanged.
- Sparse/empty: req=8'b1000_0000 with rr_ptr=7 -> grant bit 7 only, cdb_valid=2'b01, rr_ptr wraps to 0; req=0 -> cdb_valid=0 next cycle.
